fixed_point_stream_accumulator: RTL and testbench

//  Parametrised, clocked successor to our 4-bit unsigned fixed-point adder.

---
 rtl/fxp_acc_pkg.sv | 27 ++
 rtl/fxp_sat_add.sv | 33 +++
 rtl/fixed_point_stream_accumulator.sv | 140 ++++++++++++++
 tb/tb_fixed_point_stream_accumulator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_acc_pkg.sv
// +------------------------------------------------------------------------+
// | Package     : fxp_acc_pkg                                              |
// | Description : Shared types and width helper for the fixed-point        |
// |               stream accumulator.                                      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

package fxp_acc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        MODE_ADD = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    function automatic int sum_w(input int int_w, input int frac_w, input int guard_w);
        return int_w + frac_w + guard_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_sat_add.sv
// +------------------------------------------------------------------------+
// | Module      : fxp_sat_add                                              |
// | Description : Combinational SUM_W-bit unsigned adder with carry out.   |
// |               FXP_ACC_SATURATE_EN clamps the sum to all-ones on carry; |
// |               otherwise the sum wraps modulo 2^SUM_W.                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module fxp_sat_add #(
    parameter int SUM_W = 5
) (
    input  logic [SUM_W-1:0] a_i,
    input  logic [SUM_W-1:0] b_i,
    output logic [SUM_W-1:0] sum_o,
    output logic             carry_o
);

    logic [SUM_W:0] w_full;

    assign w_full  = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = w_full[SUM_W];

`ifdef FXP_ACC_SATURATE_EN
    // Addends are non-negative, so a clamped accumulator stays clamped.
    assign sum_o = w_full[SUM_W] ? {SUM_W{1'b1}} : w_full[SUM_W-1:0];
`else
    assign sum_o = w_full[SUM_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/fixed_point_stream_accumulator.sv
// +------------------------------------------------------------------------+
// | Module      : fixed_point_stream_accumulator                           |
// | Description : Unsigned fixed-point pairwise adder / packet accumulator |
// |               on a valid/ready stream with a registered result.        |
// |               Optional macro FXP_ACC_SATURATE_EN selects saturation.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module fixed_point_stream_accumulator
    import fxp_acc_pkg::*;
#(
    parameter  int INT_W   = 2,
    parameter  int FRAC_W  = 2,
    parameter  int GUARD_W = 2,
    localparam int IN_W    = INT_W + FRAC_W,
    localparam int SUM_W   = sum_w(INT_W, FRAC_W, GUARD_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic             in_mode,
    input  logic             in_last,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_ovf
);

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic               sticky_q, sticky_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic               w_fire;
    logic               w_load;
    logic               w_res_ovf;
    logic [SUM_W-1:0]   w_pair;
    logic [SUM_W-1:0]   w_base;
    logic [SUM_W-1:0]   w_add_sum;
    logic               w_add_carry;

    assign in_ready = !acc_clr && (!out_valid_q || out_ready);
    assign w_fire   = in_valid && in_ready;

    // GUARD_W >= 1 guarantees a+b alone never carries out of SUM_W.
    assign w_pair = {{GUARD_W{1'b0}}, in_a} + {{GUARD_W{1'b0}}, in_b};
    assign w_base = (state_q == ACCUM) ? acc_q : '0;

    fxp_sat_add #(
        .SUM_W (SUM_W)
    ) u_add (
        .a_i     (w_base),
        .b_i     (w_pair),
        .sum_o   (w_add_sum),
        .carry_o (w_add_carry)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        w_load    = 1'b0;
        w_res_ovf = 1'b0;
        if (acc_clr) begin
            state_d  = IDLE;
            acc_d    = '0;
            sticky_d = 1'b0;
        end else if (w_fire) begin
            if (state_q == IDLE) begin
                if (mode_e'(in_mode) == MODE_ADD) begin
                    w_load = 1'b1;
                end else if (in_last) begin
                    w_load    = 1'b1;
                    w_res_ovf = w_add_carry;
                end else begin
                    acc_d    = w_add_sum;
                    sticky_d = w_add_carry;
                    state_d  = ACCUM;
                end
            end else begin
                if (in_last) begin
                    w_load    = 1'b1;
                    w_res_ovf = sticky_q | w_add_carry;
                    acc_d     = '0;
                    sticky_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    acc_d    = w_add_sum;
                    sticky_d = sticky_q | w_add_carry;
                end
            end
        end
    end

    // A new result may load in the same cycle the old one is taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (w_load) begin
            out_valid_d = 1'b1;
            out_sum_d   = w_add_sum;
            out_ovf_d   = w_res_ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_stream_accumulator.sv
// +------------------------------------------------------------------------+
// | Module      : tb_fixed_point_stream_accumulator                        |
// | Description : Scoreboard bench for INT_W=2, FRAC_W=2, GUARD_W=1.       |
// |               Honours FXP_ACC_SATURATE_EN in its reference model.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_fixed_point_stream_accumulator;

    localparam int C_MAX = 31;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_mode;
    logic       in_last;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic       out_ovf;

    fixed_point_stream_accumulator #(
        .INT_W   (2),
        .FRAC_W  (2),
        .GUARD_W (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    string      cur_test = "reset";
    int         rdy_mode = 0;
    logic [5:0] exp_q[$];

    // Reference model state: exact packet total in quarter units.
    bit         in_pkt = 0;
    bit         pkt_acc = 0;
    int         pkt_total = 0;

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d, expected %0d (t=%0t)", cur_test, name, act, req, $time);
        end
    endfunction

    function automatic logic [5:0] model_res(input int total);
        logic ovf;
        int   s;
        ovf = (total > C_MAX);
`ifdef FXP_ACC_SATURATE_EN
        s = ovf ? C_MAX : total;
`else
        s = total % (C_MAX + 1);
`endif
        return {ovf, 5'(s)};
    endfunction

    function automatic logic pick_ready();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 2) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic model_accept(input logic [3:0] a, input logic [3:0] b,
                                input logic mode, input logic last);
        if (!in_pkt) begin
            in_pkt    = 1;
            pkt_acc   = mode;
            pkt_total = 0;
        end
        pkt_total += int'(a) + int'(b);
        if (!pkt_acc || last) begin
            exp_q.push_back(model_res(pkt_total));
            in_pkt = 0;
        end
    endtask

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b,
                             input logic mode, input logic last, output int waits);
        bit accepted;
        accepted = 0;
        waits    = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_last  = last;
        while (!accepted && waits <= 200) begin
            out_ready = pick_ready();
            #1;
            accepted = in_ready;
            @(posedge clk);
            if (!accepted) begin
                waits++;
                @(negedge clk);
            end
        end
        if (accepted) begin
            model_accept(a, b, mode, last);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL [%s] accept_timeout: beat not accepted in %0d cycles", cur_test, waits);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #6;
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_idle_valid", int'(out_valid), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        in_pkt = 0;
    endtask

    // Monitor: pops one expectation for every result handshake.
    always @(negedge clk) begin
        logic [5:0] e;
        #4;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL [%s] unexpected_output: got sum=%0d ovf=%0d, expected none",
                         cur_test, out_sum, out_ovf);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", int'(out_sum), int'(e[4:0]));
                chk("out_ovf", int'(out_ovf), int'(e[5]));
            end
        end
    end

    initial begin
        int w;
        int tot;
        logic [3:0] ra, rb;
        logic       rm;
        int         len;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_last   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        cur_test = "t1_mode0";
        send_beat(4'b1111, 4'b0001, 1'b0, 1'b0, w);
        chk("t1_latency_valid", int'(out_valid), 1);
        drain();

        cur_test = "t2_accum";
        send_beat(4'd4, 4'd4, 1'b1, 1'b0, w);
        send_beat(4'd6, 4'd2, 1'b1, 1'b0, w);
        send_beat(4'd1, 4'd1, 1'b0, 1'b1, w);
        drain();

        cur_test = "t3_overflow";
        send_beat(4'd15, 4'd15, 1'b1, 1'b0, w);
        send_beat(4'd15, 4'd15, 1'b1, 1'b1, w);
        drain();

        cur_test = "t4_backpressure";
        rdy_mode = 2;
        send_beat(4'd1, 4'd2, 1'b0, 1'b0, w);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 4'd2;
        in_b      = 4'd3;
        in_mode   = 1'b0;
        in_last   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_in_ready_low", int'(in_ready), 0);
            chk("t4_sum_stable", int'(out_sum), 3);
            chk("t4_valid_held", int'(out_valid), 1);
            @(negedge clk);
            out_ready = 1'b0;
        end
        out_ready = 1'b1;
        #1;
        chk("t4_in_ready_release", int'(in_ready), 1);
        @(posedge clk);
        model_accept(4'd2, 4'd3, 1'b0, 1'b0);
        #1;
        in_valid = 1'b0;
        rdy_mode = 0;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, w);
            tot += w;
        end
        chk("t4_full_rate_stalls", tot, 0);
        drain();

        cur_test = "t5_abort";
        send_beat(4'd4, 4'd4, 1'b1, 1'b0, w);
        send_beat(4'd2, 4'd2, 1'b1, 1'b0, w);
        @(negedge clk);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        in_a     = 4'd15;
        in_b     = 4'd15;
        in_mode  = 1'b1;
        in_last  = 1'b1;
        #1;
        chk("t5_in_ready_clr", int'(in_ready), 0);
        @(posedge clk);
        #1;
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        in_pkt   = 0;
        send_beat(4'd2, 4'd2, 1'b1, 1'b1, w);
        drain();

        cur_test = "t6_reset";
        send_beat(4'd3, 4'd3, 1'b1, 1'b0, w);
        pulse_reset();
        chk("t6_accum_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(4'd4, 4'd4, 1'b0, 1'b0, w);
        drain();
        rdy_mode = 2;
        send_beat(4'd5, 4'd6, 1'b0, 1'b0, w);
        chk("t6_pending_valid", int'(out_valid), 1);
        pulse_reset();
        chk("t6_async_valid", int'(out_valid), 0);
        chk("t6_async_sum", int'(out_sum), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        send_beat(4'd4, 4'd4, 1'b0, 1'b0, w);
        drain();

        cur_test = "random";
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            rm  = 1'($urandom_range(0, 1));
            len = rm ? $urandom_range(1, 4) : 1;
            for (int k = 0; k < len; k++) begin
                ra = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                rb = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                send_beat(ra, rb, (k == 0) ? rm : 1'($urandom_range(0, 1)),
                          (k == len - 1), w);
            end
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
